breadboard_sweeper: RTL and testbench

//  Driving/capturing end of the 4-in/10-out breadboard function interface. On start, steps
//  the input vector wxyz 0..15 into the function block, waits a settle window per vector and

---
 rtl/bb_pkg.sv | 9 +
 rtl/bb_misr.sv | 29 ++
 rtl/breadboard_sweeper.sv | 117 +++++++++++
 tb/tb_breadboard_sweeper.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bb_pkg.sv
// Shared types and constants for the breadboard sweeper and its MISR.
package bb_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [15:0] SIG_SEED  = 16'hFFFF;
  // Feedback taps: bits 15, 14, 12 and 3 of the current signature
  localparam logic [15:0] MISR_TAPS = 16'hD008;
  localparam int unsigned NUM_VEC   = 16;
endpackage

// File: rtl/bb_misr.sv
// 16-bit multiple-input signature register; load reseeds, step folds in one data word.
module bb_misr
  import bb_pkg::*;
#(
  parameter int unsigned DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [DW-1:0] i_data,
  output logic [15:0]   o_sig
);
  logic [15:0] r_sig;
  logic        w_fb;

  assign w_fb  = ^(r_sig & MISR_TAPS);
  assign o_sig = r_sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= SIG_SEED;
    end else if (i_load) begin
      r_sig <= SIG_SEED;
    end else if (i_step) begin
      r_sig <= {r_sig[14:0], w_fb} ^ 16'(i_data);
    end
  end
endmodule

// File: rtl/breadboard_sweeper.sv
// Steps wxyz 0..15 into the function block, captures responses into a 16-entry table and a MISR.
// Optional golden comparison (err_cnt/first_err) is built when SWEEPER_CHECK_EN is defined.
module breadboard_sweeper
  import bb_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned NUM_OUT    = 10
`ifdef SWEEPER_CHECK_EN
  ,
  parameter logic [NUM_OUT*NUM_VEC-1:0] GOLDEN = '0
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [3:0]         vec_out,
  input  logic [NUM_OUT-1:0] resp_in,
  output logic               busy,
  output logic               done,
  input  logic [3:0]         rd_addr,
  output logic [NUM_OUT-1:0] rd_data,
  output logic [15:0]        sig
`ifdef SWEEPER_CHECK_EN
  ,
  output logic [4:0]         err_cnt,
  output logic [3:0]         first_err
`endif
);
  state_t             r_state, w_next;
  logic [3:0]         r_idx, r_cnt;
  logic [NUM_OUT-1:0] r_table [NUM_VEC];
  logic [NUM_OUT-1:0] r_rd_data;
  logic               w_accept, w_settled, w_last_vec, w_sample;

  assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_settled  = (r_cnt == 4'(SETTLE_CYC - 1));
  assign w_last_vec = (r_idx == 4'(NUM_VEC - 1));
  assign w_sample   = (r_state == SAMPLE);

  assign vec_out = r_idx;
  assign busy    = (r_state == DRIVE) || (r_state == SAMPLE);
  assign done    = (r_state == DONE);
  assign rd_data = r_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_next = DRIVE;
      DRIVE:      if (w_settled) w_next = SAMPLE;
      SAMPLE:     w_next = w_last_vec ? DONE : DRIVE;
      default:    w_next = IDLE;
    endcase
  end

  // vec_out is the vector index itself, so it holds 4'hF through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_idx <= '0;
      r_cnt <= '0;
    end else if (r_state == DRIVE) begin
      r_cnt <= w_settled ? '0 : r_cnt + 4'd1;
    end else if (w_sample) begin
      r_cnt <= '0;
      if (!w_last_vec) r_idx <= r_idx + 4'd1;
    end
  end

  // Table deliberately has no reset: contents survive reset and aborted sweeps
  always_ff @(posedge clk) begin
    if (w_sample) r_table[r_idx] <= resp_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_data <= '0;
    else        r_rd_data <= r_table[rd_addr];
  end

  bb_misr #(.DW(NUM_OUT)) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_step (w_sample),
    .i_data (resp_in),
    .o_sig  (sig)
  );

`ifdef SWEEPER_CHECK_EN
  logic [4:0] r_err_cnt;
  logic [3:0] r_first_err;
  logic       w_mismatch;

  assign w_mismatch = (resp_in != GOLDEN[r_idx*NUM_OUT +: NUM_OUT]);
  assign err_cnt    = r_err_cnt;
  assign first_err  = r_first_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else if (w_accept) begin
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else if (w_sample && w_mismatch) begin
      if (r_err_cnt == '0)              r_first_err <= r_idx;
      if (r_err_cnt != 5'(NUM_VEC))     r_err_cnt   <= r_err_cnt + 5'd1;
    end
  end
`endif
endmodule

// File: tb/tb_breadboard_sweeper.sv
// Self-checking bench: a behavioural function block drives resp_in; table, timing, MISR and
// (with SWEEPER_CHECK_EN) golden-compare results are predicted from a high-level model.
module tb_breadboard_sweeper;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned PERIOD = SETTLE + 1;
  localparam int unsigned SWEEP  = 16 * PERIOD;

  function automatic logic [9:0] base_val(input int unsigned i);
    case (i)
      0:  return 10'h020;  1: return 10'h0A5;  2: return 10'h3C1;  3: return 10'h1F3;
      4:  return 10'h2B4;  5: return 10'h07E;  6: return 10'h155;  7: return 10'h2AA;
      8:  return 10'h0F0;  9: return 10'h30F; 10: return 10'h1C7; 11: return 10'h238;
      12: return 10'h099; 13: return 10'h366; 14: return 10'h04B; 15: return 10'h11F;
      default: return 10'h000;
    endcase
  endfunction

  function automatic logic [159:0] golden_pack();
    logic [159:0] g;
    g = '0;
    for (int i = 0; i < 16; i++) g[i*10 +: 10] = (i == 3) ? 10'h000 : base_val(i);
    return g;
  endfunction

  logic       clk, rst_n, start;
  logic [3:0] vec_out, rd_addr;
  logic [9:0] resp_in, rd_data;
  logic       busy, done;
  logic [15:0] sig;
  logic [9:0] func_tbl [16];
  logic [9:0] exp_tbl  [16];
  int unsigned n_checks, n_errors;
`ifdef SWEEPER_CHECK_EN
  logic [4:0] err_cnt;
  logic [3:0] first_err;
`endif

  assign resp_in = func_tbl[vec_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  breadboard_sweeper #(
    .SETTLE_CYC (SETTLE),
    .NUM_OUT    (10)
`ifdef SWEEPER_CHECK_EN
    , .GOLDEN   (golden_pack())
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vec_out   (vec_out),
    .resp_in   (resp_in),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .sig       (sig)
`ifdef SWEEPER_CHECK_EN
    , .err_cnt   (err_cnt)
    , .first_err (first_err)
`endif
  );

  task automatic load_func(input bit rnd);
    for (int i = 0; i < 16; i++)
      func_tbl[i] = (rnd && i != 0 && i != 3 && i != 15) ? 10'($urandom_range(0, 1023)) : base_val(i);
  endtask

  // Signature from its defining recurrence over the 16 responses in vector order
  function automatic logic [15:0] model_sig();
    logic [15:0] s;
    logic        fb;
    s = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      fb = s[15] ^ s[14] ^ s[12] ^ s[3];
      s  = {s[14:0], fb} ^ {6'b0, func_tbl[i]};
    end
    return s;
  endfunction

  task automatic do_sweep(input bit glitches);
    int unsigned cyc, ev;
    bit seen;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++;
    if ({busy, done, vec_out} !== {1'b1, 1'b0, 4'h0}) begin
      n_errors++;
      $display("FAIL accept_state: busy/done/vec got %b/%b/%h expected 1/0/0", busy, done, vec_out);
    end
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 4 * SWEEP) begin
      @(negedge clk); cyc++;
      start = glitches && (cyc == 10 || cyc == 40);
      if (done) seen = 1'b1;
      else begin
        ev = (cyc / PERIOD > 15) ? 15 : cyc / PERIOD;
        n_checks++;
        if (vec_out !== 4'(ev)) begin
          n_errors++;
          $display("FAIL vec_seq: cycle %0d got %h expected %h", cyc, vec_out, ev);
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (!seen || cyc != SWEEP) begin
      n_errors++;
      $display("FAIL done_cycle: got %0d (seen=%0d) expected %0d", cyc, seen, SWEEP);
    end
    n_checks++;
    if ({busy, vec_out} !== {1'b0, 4'hF}) begin
      n_errors++;
      $display("FAIL done_state: busy/vec got %b/%h expected 0/f", busy, vec_out);
    end
    for (int i = 0; i < 16; i++) exp_tbl[i] = func_tbl[i];
    n_checks++;
    if (sig !== model_sig()) begin
      n_errors++;
      $display("FAIL sig: got %h expected %h", sig, model_sig());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rd_addr = '0;
    load_func(1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, vec_out, sig, rd_data} !== {1'b0, 1'b0, 4'h0, 16'hFFFF, 10'h000}) begin
      n_errors++;
      $display("FAIL reset: busy/done/vec/sig/rd got %b/%b/%h/%h/%h expected 0/0/0/ffff/000",
               busy, done, vec_out, sig, rd_data);
    end
`ifdef SWEEPER_CHECK_EN
    n_checks++;
    if ({err_cnt, first_err} !== 9'h0) begin
      n_errors++;
      $display("FAIL reset_chk: err/first got %0d/%0d expected 0/0", err_cnt, first_err);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_readback();
    for (int a = 0; a < 16; a++) begin
      @(negedge clk); rd_addr = 4'(a);
      if (a > 0) begin
        #1;
        n_checks++;
        if (rd_data !== exp_tbl[a-1]) begin
          n_errors++;
          $display("FAIL rd_latency: addr %0d got %h expected %h", a, rd_data, exp_tbl[a-1]);
        end
      end
      @(negedge clk);
      n_checks++;
      if (rd_data !== exp_tbl[a]) begin
        n_errors++;
        $display("FAIL rd_data: addr %0d got %h expected %h", a, rd_data, exp_tbl[a]);
      end
    end
  endtask

  task automatic test_basic_sweep();
    load_func(1'b0);
    do_sweep(1'b0);
    test_readback();
    for (int k = 0; k < 3; k++) begin
      logic [3:0] a;
      logic [9:0] want;
      a    = (k == 0) ? 4'd0 : (k == 1) ? 4'd3 : 4'd15;
      want = (k == 0) ? 10'h020 : (k == 1) ? 10'h1F3 : 10'h11F;
      @(negedge clk); rd_addr = a;
      @(negedge clk);
      n_checks++;
      if (rd_data !== want) begin
        n_errors++;
        $display("FAIL spot_entry: addr %0d got %h expected %h", a, rd_data, want);
      end
    end
  endtask

  task automatic test_sig_rerun();
    load_func(1'b1);
    do_sweep(1'b0);
    do_sweep(1'b0);
    test_readback();
  endtask

  task automatic test_start_ignored();
    load_func(1'b1);
    do_sweep(1'b1);
    test_readback();
  endtask

  task automatic test_reset_mid();
    load_func(1'b1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, vec_out, sig} !== {1'b0, 1'b0, 4'h0, 16'hFFFF}) begin
      n_errors++;
      $display("FAIL async_abort: busy/done/vec/sig got %b/%b/%h/%h expected 0/0/0/ffff",
               busy, done, vec_out, sig);
    end
    for (int i = 0; i < 6; i++) exp_tbl[i] = func_tbl[i];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_errors++;
      $display("FAIL abort_idle: busy/done got %b/%b expected 0/0", busy, done);
    end
    test_readback();
    do_sweep(1'b0);
    test_readback();
  endtask

`ifdef SWEEPER_CHECK_EN
  task automatic test_check_en();
    logic [159:0] g;
    int unsigned  e_cnt, e_first;
    g = golden_pack();
    for (int pass = 0; pass < 3; pass++) begin
      if (pass == 2) load_func(1'b1);
      else begin
        load_func(1'b0);
        if (pass == 1) func_tbl[3] = 10'h000;
      end
      e_cnt = 0; e_first = 0;
      for (int i = 15; i >= 0; i--)
        if (func_tbl[i] != g[i*10 +: 10]) begin e_cnt++; e_first = i; end
      do_sweep(1'b0);
      n_checks++;
      if (err_cnt !== 5'(e_cnt) || first_err !== 4'(e_first)) begin
        n_errors++;
        $display("FAIL golden_cmp: pass %0d err/first got %0d/%0d expected %0d/%0d",
                 pass, err_cnt, first_err, e_cnt, e_first);
      end
    end
  endtask
`endif

  initial begin
    n_checks = 0; n_errors = 0;
    test_reset();
    test_basic_sweep();
    test_sig_rerun();
    test_start_ignored();
    test_reset_mid();
`ifdef SWEEPER_CHECK_EN
    test_check_en();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
